// File: rtl/div_iter_if.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_if
// Brief    : start/ready divide handshake between hazard unit and divider.
// Revision : 1.0 - initial release
// ============================================================================
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o
  );
endinterface
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Brief    : radix-2 restoring divider, one quotient bit per cycle, {rem,quo}.
//            Optional zero-operand early-out via `define DIV_EARLY_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter #(
  parameter int WIDTH = 32
) (
  input wire        clk,
  input wire        rst,
  div_iter_if.slave bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [5:0] c_LAST_ITER = 6'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [5:0]         r_counter;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_dividendRaw;
  logic               r_dividendNeg;
  logic               r_divisorNeg;
  logic [2*WIDTH-1:0] r_result;

  logic               w_dividendNeg;
  logic               w_divisorNeg;
  logic [WIDTH-1:0]   w_dividendAbs;
  logic [WIDTH-1:0]   w_divisorAbs;
  logic               w_nonNeg;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_remNext;
  logic [WIDTH-1:0]   w_quoNext;
  logic [WIDTH-1:0]   w_remFix;
  logic [WIDTH-1:0]   w_quoFix;
  logic [2*WIDTH-1:0] w_final;

  assign w_dividendNeg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign w_divisorNeg  = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign w_dividendAbs = w_dividendNeg ? -bus.opdata1_i : bus.opdata1_i;
  assign w_divisorAbs  = w_divisorNeg  ? -bus.opdata2_i : bus.opdata2_i;

  // Trial subtract on the shifted upper WIDTH+1 bits; when it succeeds the
  // difference is below the divisor, so WIDTH bits of it are exact.
  assign w_nonNeg  = {r_rem, r_quo[WIDTH-1]} >= {1'b0, r_divisor};
  assign w_diff    = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]} - r_divisor;
  assign w_remNext = w_nonNeg ? w_diff : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_quoNext = {r_quo[WIDTH-2:0], w_nonNeg};

  // Sign flags are already masked by signed_div_i at accept time.
  assign w_quoFix = (r_dividendNeg ^ r_divisorNeg) ? -w_quoNext : w_quoNext;
  assign w_remFix = r_dividendNeg ? -w_remNext : w_remNext;
  assign w_final  = (r_divisor == '0) ? {r_dividendRaw, {WIDTH{1'b1}}}
                                      : {w_remFix, w_quoFix};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= c_IDLE;
      r_counter     <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_divisor     <= '0;
      r_dividendRaw <= '0;
      r_dividendNeg <= 1'b0;
      r_divisorNeg  <= 1'b0;
      r_result      <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            r_counter     <= '0;
            r_rem         <= '0;
            r_quo         <= w_dividendAbs;
            r_divisor     <= w_divisorAbs;
            r_dividendRaw <= bus.opdata1_i;
            r_dividendNeg <= w_dividendNeg;
            r_divisorNeg  <= w_divisorNeg;
`ifdef DIV_EARLY_OUT_EN
            if (bus.opdata2_i == '0) begin
              r_result <= {bus.opdata1_i, {WIDTH{1'b1}}};
              r_state  <= c_DONE;
            end else if (bus.opdata1_i == '0) begin
              r_result <= '0;
              r_state  <= c_DONE;
            end else begin
              r_state  <= c_CALC;
            end
`else
            r_state <= c_CALC;
`endif
          end
        end
        c_CALC: begin
          if (bus.annul_i) begin
            r_state   <= c_IDLE;
            r_counter <= '0;
          end else begin
            r_rem     <= w_remNext;
            r_quo     <= w_quoNext;
            r_counter <= r_counter + 6'd1;
            if (r_counter == c_LAST_ITER) begin
              r_result  <= w_final;
              r_counter <= '0;
              r_state   <= c_DONE;
            end
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.ready_o  = (r_state == c_DONE);
  assign bus.result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter
// Brief    : directed scoreboard bench for div_iter (DIV/DIVU, annul, reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;
  localparam int WIDTH = 32;

  typedef struct {
    logic [63:0] result;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_iter_if #(.WIDTH(WIDTH)) bus ();
  div_iter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [63:0] lastRes = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int expLat(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    return (a == 32'd0 || b == 32'd0) ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!s) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {r, q};
  endfunction

  // Edges counted from the accepting edge (inclusive) until ready_o is seen.
  task automatic waitReady(output int lat);
    lat = 1;
    while (bus.ready_o !== 1'b1 && lat <= 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pushExp(input logic [63:0] res, input int lat);
    exp_t e;
    e.result = res;
    e.lat    = lat;
    sb.push_back(e);
  endtask

  task automatic runOp(input string tag, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] expRes);
    exp_t got;
    int   lat;
    pushExp(expRes, expLat(a, b));
    @(negedge clk);
    bus.start_i      = 1'b1;
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    @(posedge clk); #1;
    waitReady(lat);
    bus.start_i = 1'b0;
    got = sb.pop_front();
    check({tag, " latency"}, 64'(lat), 64'(got.lat));
    check({tag, " result"}, bus.result_o, got.result);
    lastRes = got.result;
    @(posedge clk); #1;
    check({tag, " ready drops"}, 64'(bus.ready_o), 64'd0);
    check({tag, " result held"}, bus.result_o, got.result);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        sawReady;
    int          lat;
    exp_t        got;
    logic [31:0] ra, rb;

    rst = 1'b1;
    bus.start_i = 1'b0; bus.signed_div_i = 1'b0; bus.annul_i = 1'b0;
    bus.opdata1_i = '0; bus.opdata2_i = '0;
    #12;
    check("reset ready", 64'(bus.ready_o), 64'd0);
    check("reset result", bus.result_o, 64'd0);
    @(negedge clk); rst = 1'b0;

    runOp("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
    runOp("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    runOp("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
    runOp("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    runOp("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF});
    runOp("divu by 0", 1'b0, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF});
    runOp("div by 0", 1'b1, 32'h8765_4321, 32'd0, {32'h8765_4321, 32'hFFFF_FFFF});
    runOp("div 0/5", 1'b1, 32'd0, 32'd5, 64'd0);
    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom_range(1, 50000);
      runOp("rand divu", 1'b0, ra, rb, model(1'b0, ra, rb));
      ra = $urandom; rb = $urandom;
      runOp("rand div", 1'b1, ra, rb, model(1'b1, ra, rb));
    end

    // Annul mid-CALC: no pulse, result untouched.
    @(negedge clk);
    bus.start_i = 1'b1; bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    sawReady = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (bus.ready_o) sawReady = 1'b1; end
    @(negedge clk); bus.annul_i = 1'b1;
    @(posedge clk); #1; bus.annul_i = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus.ready_o) sawReady = 1'b1; end
    check("annul no ready", 64'(sawReady), 64'd0);
    check("annul result kept", bus.result_o, lastRes);
    runOp("divu 9/3 after annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

    // Asynchronous reset between edges while in CALC.
    @(negedge clk);
    bus.start_i = 1'b1; bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async rst ready", 64'(bus.ready_o), 64'd0);
    check("async rst result", bus.result_o, 64'd0);
    @(negedge clk); rst = 1'b0;
    sawReady = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus.ready_o) sawReady = 1'b1; end
    check("post rst idle", 64'(sawReady), 64'd0);

    // Back-to-back: start stays high through DONE.
    pushExp({32'd2, 32'd14}, 33);
    @(negedge clk);
    bus.start_i = 1'b1; bus.signed_div_i = 1'b0;
    bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
    @(posedge clk); #1;
    waitReady(lat);
    got = sb.pop_front();
    check("b2b first latency", 64'(lat), 64'(got.lat));
    check("b2b first result", bus.result_o, got.result);
    bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd6;
    pushExp({32'd2, 32'd8}, 34);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus.ready_o !== 1'b1 && lat < 100);
    bus.start_i = 1'b0;
    got = sb.pop_front();
    check("b2b second spacing", 64'(lat), 64'(got.lat));
    check("b2b second result", bus.result_o, got.result);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle radix-2 restoring divider for the EX stage. It is the responder side of the start/ready divide handshake driven by the hazard unit.
- Accepts DIV/DIVU operands on start, iterates one quotient bit per cycle, then pulses ready with {remainder, quotient} for the HI/LO write path.
- Holds the result stable until the next accepted operation.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start_i  input  1  divide request; held high by the hazard unit until ready_o is seen.
signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU.
opdata1_i  input  WIDTH  dividend.
opdata2_i  input  WIDTH  divisor.
annul_i  input  1  cancel the in-flight operation (exception/flush).
result_o  output  2*WIDTH  {remainder[WIDTH-1:0] -> HI, quotient[WIDTH-1:0] -> LO}.
ready_o  output  1  one-cycle completion pulse; result_o is valid while high and afterwards.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, counter=0, result_o=0, ready_o=0.
- States:
  - IDLE: start_i=1 and annul_i=0 at an edge (call it E0) -> latch operands, signed_div_i, and sign bits. Operands are converted to absolute value when signed. Next state is CALC (or DONE if early-out fires; see Optional Feature).
  - CALC: one iteration per edge with a 6-bit counter 0..WIDTH-1.
    - Shift {rem, quo} left 1 bit.
    - Trial subtract divisor from the upper WIDTH+1 bits. If the result is non-negative, commit it and set quo[0]=1.
    - On the edge where counter=WIDTH-1 (E32 for WIDTH=32): apply sign fixup, load result_o, go to DONE.
  - DONE: ready_o=1 for exactly this one cycle. Next edge -> IDLE unconditionally. start_i is ignored in DONE.
- ready_o = (state==DONE), registered, never combinational from inputs.
- Latency: start accepted at E0 -> ready_o high in the cycle after E32 (33 edges). A back-to-back divide is accepted at the first IDLE edge.
- Sign fixup (signed only):
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - -2^31 / -1 yields quotient 0x80000000, remainder 0 (wrap, no trap).
- Divisor zero: result_o = {dividend_as_given, all-ones}. This holds for signed and unsigned, with or without the optional feature.
- annul_i=1 in CALC or at an accepting edge: return to / stay in IDLE. ready_o is not asserted and result_o is not updated. annul_i in DONE has no effect, because the pulse is already committed.
- Operand inputs are only sampled at E0; changes during CALC have no effect.
- result_o changes only on entry to DONE.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: at E0, a divisor of 0 or a dividend of 0 skips CALC and goes directly to DONE with the final result loaded. ready_o is high in the cycle after E0.
  - Divisor 0: result per the divisor-zero rule.
  - Dividend 0: result 0.
- Undefined: all operations take the full WIDTH iterations. The divisor-zero result is identical, produced by the iteration itself plus forced override at fixup.

Test Plan:
- DIVU 100/7, start held until ready -> ready_o high exactly 33 edges after accept; result_o = {0x00000002, 0x0000000E}; ready_o low the next cycle.
- DIV -7/2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> result_o = {0x00000000, 0x80000000}. DIVU 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
- Divisor 0 with dividend 0x12345678 -> result_o = {0x12345678, 0xFFFFFFFF}. Latency is 1 with DIV_EARLY_OUT_EN defined, 33 without.
- annul_i pulsed at iteration 10, then a new DIVU 9/3 started -> no ready_o for the first operation; second operation returns {0, 3} after 33 edges.
- rst asserted asynchronously mid-CALC (between edges) -> ready_o and result_o are 0 immediately. The back-to-back case (start kept high after DONE) starts a new operation on the first IDLE edge with no duplicate ready_o pulse.
